// File: rtl/sonar_frame_serializer.sv
//------------------------------------------------------------------------------
// sonar_frame_serializer
//   Latches NUM_FIELDS BCD fields on start and streams "F(n-1),...,F0<TERM>"
//   as 7-bit ASCII over a valid/ready handshake.
//   Optional macro SONAR_SERIALIZER_ZERO_BLANK_EN: leading zeros sent as space.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sonar_frame_serializer #(
    parameter int         NUM_FIELDS = 2,
    parameter int         DIGITS     = 3,
    parameter logic [6:0] SEP_CHAR   = 7'h2C,
    parameter logic [6:0] TERM_CHAR  = 7'h23
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_FIELDS*DIGITS*4-1:0] fields_bcd,
    input  logic                           tx_ready,
    output logic [6:0]                     tx_data,
    output logic                           tx_valid,
    output logic                           busy,
    output logic                           done
);

    localparam int c_field_w   = DIGITS * 4;
    localparam int c_bus_w     = NUM_FIELDS * c_field_w;
    localparam int c_frame_len = NUM_FIELDS * DIGITS + (NUM_FIELDS - 1) + 1;
    localparam int c_idx_w     = (c_frame_len > 1) ? $clog2(c_frame_len) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_frame_len - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_bus_w-1:0]   r_fields;
    logic [c_idx_w-1:0]   r_index;
    logic [6:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [c_bus_w-1:0]   w_src;
    logic [c_idx_w-1:0]   w_next_idx;
    logic [6:0]           w_next_char;
    logic [6:0]           w_frame [c_frame_len];

    // In IDLE the first character is built straight from the input bus so it
    // can be registered on the same edge that captures the fields.
    assign w_src      = (r_state == ST_IDLE) ? fields_bcd : r_fields;
    assign w_next_idx = (r_state == ST_IDLE) ? '0 : r_index + c_idx_w'(1);

    function automatic logic [6:0] enc_digit(input logic [3:0] nib);
        return (nib > 4'd9) ? 7'h3F : {3'b011, nib};
    endfunction

    // Slot f of the frame carries field NUM_FIELDS-1-f, digits MSB first.
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
        localparam int c_k    = NUM_FIELDS - 1 - f;
        localparam int c_base = f * (DIGITS + 1);

        logic [3:0] w_nib [DIGITS];

        for (genvar j = 0; j < DIGITS; j++) begin : g_nib
            assign w_nib[j] = w_src[c_k*c_field_w + (DIGITS-1-j)*4 +: 4];
        end

`ifdef SONAR_SERIALIZER_ZERO_BLANK_EN
        logic [DIGITS-1:0] w_blank;

        // A digit blanks only while every digit above it in the field was zero;
        // the last digit of a field is never blanked.
        for (genvar j = 0; j < DIGITS; j++) begin : g_blank
            if (j == DIGITS - 1) begin : g_last
                assign w_blank[j] = 1'b0;
            end else if (j == 0) begin : g_first
                assign w_blank[j] = (w_nib[j] == 4'd0);
            end else begin : g_mid
                assign w_blank[j] = w_blank[j-1] & (w_nib[j] == 4'd0);
            end
            assign w_frame[c_base + j] = w_blank[j] ? 7'h20 : enc_digit(w_nib[j]);
        end
`else
        for (genvar j = 0; j < DIGITS; j++) begin : g_digit
            assign w_frame[c_base + j] = enc_digit(w_nib[j]);
        end
`endif

        if (f < NUM_FIELDS - 1) begin : g_sep
            assign w_frame[c_base + DIGITS] = SEP_CHAR;
        end
    end

    assign w_frame[c_frame_len - 1] = TERM_CHAR;
    assign w_next_char = w_frame[w_next_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fields   <= '0;
            r_index    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_fields   <= fields_bcd;
                        r_index    <= '0;
                        r_tx_data  <= w_next_char;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        if (r_index == c_last_idx) begin
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= ST_DONE;
                        end else begin
                            r_index   <= w_next_idx;
                            r_tx_data <= w_next_char;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_index <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_index    <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sonar_frame_serializer.sv
//------------------------------------------------------------------------------
// tb_sonar_frame_serializer
//   Randomised bench with a behavioural frame model for sonar_frame_serializer.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sonar_frame_serializer;

    localparam int         NF   = 2;
    localparam int         D    = 3;
    localparam int         W    = NF * D * 4;
    localparam logic [6:0] SEP  = 7'h2C;
    localparam logic [6:0] TERM = 7'h23;
    localparam int         L    = NF * D + (NF - 1) + 1;
`ifdef SONAR_SERIALIZER_ZERO_BLANK_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] fields_bcd;
    logic         tx_ready;
    logic [6:0]   tx_data;
    logic         tx_valid;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    sonar_frame_serializer #(
        .NUM_FIELDS (NF),
        .DIGITS     (D),
        .SEP_CHAR   (SEP),
        .TERM_CHAR  (TERM)
    ) u_dut (
        .clock      (clk),
        .reset      (rst),
        .start      (start),
        .fields_bcd (fields_bcd),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: walk fields high to low, digits high to low.
    task automatic build_expected(input logic [W-1:0] f);
        logic [W-1:0] sh;
        logic [3:0]   nib;
        bit           lead;
        exp_q.delete();
        for (int s = NF - 1; s >= 0; s--) begin
            lead = 1'b1;
            for (int d = D - 1; d >= 0; d--) begin
                sh  = f >> ((s * D + d) * 4);
                nib = sh[3:0];
                if (nib > 9) begin
                    exp_q.push_back(7'h3F);
                    lead = 1'b0;
                end else if (ZB && lead && nib == 0 && d != 0) begin
                    exp_q.push_back(7'h20);
                end else begin
                    exp_q.push_back(7'h30 + 7'(nib));
                    lead = 1'b0;
                end
            end
            if (s != 0) exp_q.push_back(SEP);
        end
        exp_q.push_back(TERM);
    endtask

    task automatic run_frame(input logic [W-1:0] f, input bit rand_ready, input bit disturb);
        logic [6:0] got[$];
        int         cyc       = 0;
        int         busy_cnt  = 0;
        int         done_cnt  = 0;
        int         stalls    = 0;
        bit         fin       = 1'b0;
        bit         prev_stall = 1'b0;
        logic [6:0] prev_data = '0;
        build_expected(f);
        @(negedge clk);
        fields_bcd = f;
        start      = 1'b1;
        tx_ready   = 1'b1;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (disturb && cyc >= 2 && cyc <= 4) begin
                start      = 1'b1;
                fields_bcd = {(NF*D){4'h5}};
            end
            if (cyc == 1) check_value("first_valid", 32'(tx_valid), 32'd1);
            if (prev_stall) begin
                check_value("stall_valid", 32'(tx_valid), 32'd1);
                check_value("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                fin = 1'b1;
                if (disturb) start = 1'b1;
            end
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (prev_stall) stalls++;
        end
        if (!fin) check_value("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        check_value("done_pulse_end", 32'(done), 32'd0);
        check_value("busy_after", 32'(busy), 32'd0);
        check_value("valid_after", 32'(tx_valid), 32'd0);
        check_value("frame_len", 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_value($sformatf("char%0d", i), 32'(got[i]), 32'(exp_q[i]));
        check_value("done_count", 32'(done_cnt), 32'd1);
        check_value("busy_cycles", 32'(busy_cnt), 32'(L + 1 + stalls));
        if (disturb) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check_value("no_requeue_busy", 32'(busy), 32'd0);
                check_value("no_requeue_valid", 32'(tx_valid), 32'd0);
            end
        end
    endtask

    task automatic reset_mid_frame(input logic [W-1:0] f);
        int acc = 0;
        int cyc = 0;
        @(negedge clk);
        fields_bcd = f;
        start      = 1'b1;
        tx_ready   = 1'b1;
        while (acc < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (tx_valid && tx_ready) acc++;
        end
        if (acc < 3) check_value("reset_wait_timeout", 32'd0, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_value("abort_valid", 32'(tx_valid), 32'd0);
        check_value("abort_busy", 32'(busy), 32'd0);
        check_value("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] f;
        rst        = 1'b1;
        start      = 1'b0;
        tx_ready   = 1'b0;
        fields_bcd = '0;
        repeat (3) @(negedge clk);
        check_value("rst_valid", 32'(tx_valid), 32'd0);
        check_value("rst_data", 32'(tx_data), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_frame(W'(24'h090123), 1'b0, 1'b0);
        run_frame(W'(24'h090123), 1'b1, 1'b0);
        run_frame(W'(24'h090123), 1'b0, 1'b1);
        run_frame(W'(24'h09012A), 1'b0, 1'b0);
        reset_mid_frame(W'(24'h090123));
        run_frame(W'(24'h090123), 1'b0, 1'b0);
        run_frame(W'(24'h000000), 1'b1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < NF * D; n++) begin
                if ($urandom_range(0, 7) == 0)
                    f[n*4 +: 4] = 4'($urandom_range(10, 15));
                else if ($urandom_range(0, 2) == 0)
                    f[n*4 +: 4] = 4'd0;
                else
                    f[n*4 +: 4] = 4'($urandom_range(0, 9));
            end
            run_frame(f, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sonar_frame_serializer.md
Name: sonar_frame_serializer

Overview:
Parametrised successor to the fixed 8-character sonar ASCII frame builder. It latches NUM_FIELDS fields of DIGITS BCD digits each on a start pulse. It then streams the frame "F(n-1),...,F1,F0<TERM>" one 7-bit ASCII character at a time to the UART transmitter over a valid/ready handshake. It sits between the measurement/angle BCD converters and the serial TX block, and replaces the external select counter with its own FSM.

Parameters:
NUM_FIELDS, 2, number of numeric fields per frame (>=1); field NUM_FIELDS-1 is sent first.
DIGITS, 3, BCD digits per field (>=1).
SEP_CHAR, 7'h2C, separator placed between fields (',').
TERM_CHAR, 7'h23, terminator placed after the last field ('#').

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request to send one frame; sampled only in IDLE
fields_bcd  in  NUM_FIELDS*DIGITS*4  packed fields; field k at bits [(k+1)*DIGITS*4-1 : k*DIGITS*4]; most significant digit in the top nibble of each field
tx_ready  in  1  UART TX can accept a character this cycle
tx_data  out  7  ASCII character presented to TX
tx_valid  out  1  tx_data is valid
busy  out  1  frame in progress (SEND or DONE)
done  out  1  one-cycle pulse after the terminator is accepted

Behaviour:
- Reset (async, any state): FSM to IDLE, char index 0, field latch cleared. tx_valid=0, tx_data=0, busy=0, done=0.
- Frame length L = NUM_FIELDS*DIGITS + (NUM_FIELDS-1) + 1. With the defaults L=8.
- Char index counter width is $clog2(L) (min 1). It counts 0..L-1 with no wrap inside a frame.
- Order: for each field from NUM_FIELDS-1 down to 0, send its DIGITS digits MSB-first. Send SEP_CHAR after every field except field 0. Send TERM_CHAR last.
- Digit encoding: nibble 0-9 -> {3'b011, nibble}. Nibble 10-15 -> '?' (7'h3F).
- FSM:
  - IDLE: tx_valid=0, busy=0. If start=1, capture fields_bcd into an internal register, index:=0, go to SEND. tx_valid rises the next cycle; latency from start to first tx_valid is 1 cycle.
  - SEND: tx_valid=1, tx_data=char(index), registered and derived from the latched copy. A transfer occurs on an edge where tx_valid && tx_ready.
    - On transfer with index<L-1: index+1, stay in SEND. The next char is presented the following cycle, with no bubble.
    - On transfer with index=L-1: go to DONE, tx_valid drops.
    - If tx_ready=0: hold tx_data and tx_valid stable indefinitely.
  - DONE: one cycle, done=1, busy=1, tx_valid=0, then go to IDLE.
- start while in SEND or DONE is ignored, not queued. start in the same cycle that DONE returns to IDLE is also ignored.
- Changes on fields_bcd after capture do not affect the frame in flight.
- tx_ready is ignored outside SEND.
- Reset asserted mid-frame aborts immediately. No partial terminator is sent. tx_valid is low while reset is high.
- Best case: L+2 cycles per frame from start to done.

Optional Feature:
Macro SONAR_SERIALIZER_ZERO_BLANK_EN.
- Defined: within each field, leading '0' digits are sent as space (7'h20). The last digit of a field is always sent numerically, so field 000 -> "  0". Blanking restarts at each field. A non-BCD digit ends blanking and is sent as '?'.
- Undefined: all digits are sent numerically, including leading zeros. Frame length is unchanged in both cases.

Test Plan:
- Defaults, fields_bcd=24'h090_123, tx_ready=1 constant, start pulse -> tx_data sequence 30,39,30,2C,31,32,33,23 on 8 consecutive cycles. done pulses exactly once, 1 cycle after 23 is accepted. busy is high for 9 cycles.
- Same frame, tx_ready toggling 1-0-0-1 pseudo-randomly -> identical 8-character sequence. tx_data stays stable while tx_valid=1 and tx_ready=0. No character is dropped or duplicated.
- fields_bcd changed to 24'h555_555 and start re-pulsed during SEND -> in-flight frame still sends 090,123#. A second frame starts only after a start that arrives in IDLE.
- Nibble 4'hA in field 0 LSB (24'h090_12A) -> 7th char is 3F, all others unchanged.
- Reset asserted after 3rd char accepted -> tx_valid=0 and busy=0 immediately. The next start sends a full frame beginning with the MSB of field NUM_FIELDS-1.
- NUM_FIELDS=3, DIGITS=2, macro defined, fields_bcd=24'h05_00_42 -> sequence 20,35,2C,20,30,2C,34,32,23 (" 5, 0,42#").
